pwm_multi_channel: RTL

Parametrised successor to the single-channel PWM and its separate SLOW_CLK divider. It drives NUM_CH PWM outputs from one shared period counter, which advances on a built-in programmable prescaler tick (a clock enable, not a derived clock). It supports edge-aligned and center-aligned modes. Duty values are double-buffered so they update glitch-free at period boundaries. It sits between control logic (switches or register interface) and the Basys3 output pins.

---
 rtl/pwm_multi_channel.sv | 119 +++++++++++
 1 files changed

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared period counter on a prescaler clock-enable,
// edge or center aligned, with double-buffered duties swapped at period boundaries.
module pwm_multi_channel #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PRESC_W = 16,
  parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [CNT_W-1:0]   period,
  input  logic               center_mode,
  input  logic               duty_wr,
  input  logic [CH_W-1:0]    duty_ch,
  input  logic [CNT_W-1:0]   duty_val,
  output logic [NUM_CH-1:0]  pwm_out,
  output logic               period_start,
  output logic               update_pending
);

  localparam logic [0:0] DIR_UP   = 1'b0;
  localparam logic [0:0] DIR_DOWN = 1'b1;

  logic [PRESC_W-1:0] presc_cnt, presc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [0:0]         dir, dir_nxt;
  logic [CNT_W-1:0]   period_l;
  logic               mode_l;
  logic               was_en;
  logic               bnd_q;
  logic [CNT_W-1:0]   shadow [NUM_CH];
  logic [CNT_W-1:0]   active [NUM_CH];

  logic run, start, tick, boundary, wr_ok;

  // Next-state for prescaler and period counter, boundary detection
  always_comb begin
    run       = enable & was_en;
    start     = enable & ~was_en;
    tick      = run && (presc_cnt == prescale);
    presc_nxt = '0;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    wr_ok     = duty_wr && (32'(duty_ch) < NUM_CH);

    if (run) begin
      presc_nxt = (presc_cnt >= prescale) ? '0 : presc_cnt + PRESC_W'(1);
    end

    if (!enable) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (tick) begin
      if (!mode_l || (period_l == '0)) begin
        cnt_nxt = (cnt == period_l) ? '0 : cnt + CNT_W'(1);
      end else if ((dir == DIR_UP) && (cnt != period_l)) begin
        cnt_nxt = cnt + CNT_W'(1);
      end else begin
        // Turning at the top or descending; reaching zero restarts upward
        cnt_nxt = cnt - CNT_W'(1);
        dir_nxt = (cnt_nxt == '0) ? DIR_UP : DIR_DOWN;
      end
    end

    boundary = start | (tick && (cnt_nxt == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt      <= '0;
      cnt            <= '0;
      dir            <= DIR_UP;
      period_l       <= '0;
      mode_l         <= 1'b0;
      was_en         <= 1'b0;
      bnd_q          <= 1'b0;
      update_pending <= 1'b0;
      pwm_out        <= '0;
      period_start   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      presc_cnt <= presc_nxt;
      cnt       <= cnt_nxt;
      dir       <= dir_nxt;
      was_en    <= enable;
      bnd_q     <= boundary;

      if (boundary) begin
        period_l <= period;
        mode_l   <= center_mode;
      end

      // Same-cycle write bypasses the shadow straight into active at a boundary
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_ok && (duty_ch == CH_W'(i))) begin
          shadow[i] <= duty_val;
        end
        if (boundary) begin
          active[i] <= (wr_ok && (duty_ch == CH_W'(i))) ? duty_val : shadow[i];
        end
        pwm_out[i] <= run && (cnt < active[i]);
      end

      if (boundary) begin
        update_pending <= 1'b0;
      end else if (wr_ok) begin
        update_pending <= 1'b1;
      end

      period_start <= run && bnd_q;
    end
  end

endmodule
